// File: rtl/tdc_decoder.sv
// tdc_decoder: readout for the TDC latch bank.
// Three-stage pipeline: capture -> bubble correction + edge search -> outputs
// and half-period IIR average.
// Optional build macro: TDC_BUBBLE_CORR_EN enables majority-of-3 bubble
// correction ahead of the edge encoders; when undefined the captured word
// feeds the encoders directly and latency is unchanged.
module tdc_decoder #(
  parameter int NSTAGES = 64,
  parameter int PW      = $clog2(NSTAGES) + 1,
  parameter int AVG_SH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sample_valid,
  input  logic [NSTAGES-1:0]   tdc_q,
  output logic [PW-1:0]        rise_pos,
  output logic [PW-1:0]        fall_pos,
  output logic [PW+AVG_SH-1:0] period_avg,
  output logic [PW-1:0]        phase_out,
  output logic                 edge_err,
  output logic                 out_valid
);

  localparam int AW = PW + AVG_SH;

  typedef enum logic {INIT, TRACK} period_state_t;

  logic [NSTAGES-1:0] q_p1;
  logic               vld_p1;
  logic [NSTAGES-1:0] corr_p1;
  logic [PW:0]        rise_srch_p1;
  logic [PW:0]        fall_srch_p1;
  logic [PW-1:0]      rise_p2;
  logic [PW-1:0]      fall_p2;
  logic               rfnd_p2;
  logic               ffnd_p2;
  logic               vld_p2;
  logic [PW-1:0]      meas_p2;
  logic               vld_p3;
  period_state_t      state;

`ifdef TDC_BUBBLE_CORR_EN
  // Majority of each bit and its neighbours; the end bits reuse themselves
  // as the missing neighbour, which leaves them unchanged.
  function automatic logic [NSTAGES-1:0] bubble_fix(input logic [NSTAGES-1:0] q);
    logic [NSTAGES-1:0] r;
    logic lo, hi;
    r = '0;
    for (int i = 0; i < NSTAGES; i++) begin
      lo   = q[(i == 0) ? 0 : i - 1];
      hi   = q[(i == NSTAGES - 1) ? NSTAGES - 1 : i + 1];
      r[i] = (lo & q[i]) | (lo & hi) | (q[i] & hi);
    end
    return r;
  endfunction
`endif

  // Lowest-index transition scanning upward from bit 1; returns {found, pos}
  // with pos = NSTAGES when nothing is found.
  function automatic logic [PW:0] find_edge(input logic [NSTAGES-1:0] q,
                                            input logic rising);
    logic          found;
    logic [PW-1:0] pos;
    logic          hit;
    found = 1'b0;
    pos   = PW'(NSTAGES);
    for (int i = 1; i < NSTAGES; i++) begin
      hit = rising ? (!q[i-1] && q[i]) : (q[i-1] && !q[i]);
      if (!found && hit) begin
        found = 1'b1;
        pos   = PW'(i);
      end
    end
    return {found, pos};
  endfunction

  // Clamp a signed intermediate into the unsigned average range.
  function automatic logic [AW-1:0] sat_avg(input logic signed [AW:0] v);
    logic signed [AW:0] vmax;
    vmax = {1'b0, {AW{1'b1}}};
    if (v < 0)
      return '0;
    else if (v > vmax)
      return {AW{1'b1}};
    else
      return v[AW-1:0];
  endfunction

  // One first-order IIR step: avg + ((meas << AVG_SH) - avg) >>> AVG_SH.
  function automatic logic [AW-1:0] iir_step(input logic [AW-1:0] avg,
                                             input logic [PW-1:0] meas);
    logic signed [AW:0] target;
    logic signed [AW:0] cur;
    logic signed [AW:0] diff;
    logic signed [AW:0] nxt;
    target = signed'({1'b0, meas, {AVG_SH{1'b0}}});
    cur    = signed'({1'b0, avg});
    diff   = target - cur;
    nxt    = cur + (diff >>> AVG_SH);
    return sat_avg(nxt);
  endfunction

  // ---- stage 1: capture ----
  // Valid flag advances only while enabled; dropped strobes never enter.
  always_ff @(posedge clk) begin
    if (rst)
      vld_p1 <= 1'b0;
    else if (en)
      vld_p1 <= sample_valid;
  end

  // Latch word captured on an accepted strobe.
  always_ff @(posedge clk) begin
    if (en && sample_valid)
      q_p1 <= tdc_q;
  end

  // ---- stage 2: bubble correction and edge search ----
  // Corrected (or raw) word and both priority encoders.
  always_comb begin
`ifdef TDC_BUBBLE_CORR_EN
    corr_p1 = bubble_fix(q_p1);
`else
    corr_p1 = q_p1;
`endif
    rise_srch_p1 = find_edge(corr_p1, 1'b1);
    fall_srch_p1 = find_edge(corr_p1, 1'b0);
  end

  // Stage-2 valid flag.
  always_ff @(posedge clk) begin
    if (rst)
      vld_p2 <= 1'b0;
    else if (en)
      vld_p2 <= vld_p1;
  end

  // Stage-2 edge positions and found flags.
  always_ff @(posedge clk) begin
    if (en && vld_p1) begin
      {rfnd_p2, rise_p2} <= rise_srch_p1;
      {ffnd_p2, fall_p2} <= fall_srch_p1;
    end
  end

  // ---- stage 3: outputs and period tracking ----
  // Half-period distance between the two edges.
  always_comb begin
    meas_p2 = (fall_p2 >= rise_p2) ? (fall_p2 - rise_p2) : (rise_p2 - fall_p2);
  end

  // Output registers plus the INIT/TRACK period state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p3     <= 1'b0;
      rise_pos   <= '0;
      fall_pos   <= '0;
      phase_out  <= '0;
      edge_err   <= 1'b0;
      period_avg <= '0;
      state      <= INIT;
    end else if (en) begin
      vld_p3 <= vld_p2;
      if (vld_p2) begin
        rise_pos  <= rise_p2;
        fall_pos  <= fall_p2;
        edge_err  <= !rfnd_p2 && !ffnd_p2;
        phase_out <= rfnd_p2 ? rise_p2 : (ffnd_p2 ? fall_p2 : '0);
        if (rfnd_p2 && ffnd_p2) begin
          case (state)
            INIT: begin
              period_avg <= {meas_p2, {AVG_SH{1'b0}}};
              state      <= TRACK;
            end
            TRACK: period_avg <= iir_step(period_avg, meas_p2);
            default: state <= INIT;
          endcase
        end
      end
    end
  end

  // A frozen pipeline never advertises valid data; a held strobe reappears
  // once the pipeline resumes, so each sample is reported exactly once.
  assign out_valid = vld_p3 && en;

endmodule

// File: doc/tdc_decoder.md
# tdc_decoder

Synthesizable readout for the TDC latch bank: samples the thermometer word held by the negative-enable delay-line latches, removes bubbles, locates the rising and falling edges of the delayed reference, and outputs a binary fractional phase plus a running DCO half-period estimate in stage units. It sits between the TDC latch array and the ADPLL phase detector. It consumes the data the latches produce.

## Interface
- `NSTAGES`, 64: number of TDC latch outputs (thermometer width), power of two, 8..256.
- `PW`, `$clog2(NSTAGES)+1`: width of the position and period outputs.
- `AVG_SH`, 4: IIR shift for the period average (weight 2^-AVG_SH).
- `clk` input 1: reference clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: block enable. When 0, the pipeline holds and `out_valid` is 0.
- `sample_valid` input 1: one-cycle strobe. `tdc_q` is stable and must be captured this cycle.
- `tdc_q` input NSTAGES: latch outputs. Bit 0 is the first delay stage.
- `rise_pos` output PW: index of the first 0→1 transition (bit i-1 = 0, bit i = 1).
- `fall_pos` output PW: index of the first 1→0 transition.
- `period_avg` output PW+AVG_SH: averaged half-period, stage units, with AVG_SH fractional bits.
- `phase_out` output PW: fractional phase = `rise_pos` if a rise was found, else `fall_pos`.
- `edge_err` output 1: no transition found in the current sample.
- `out_valid` output 1: one-cycle strobe qualifying all outputs.

## Operation
- **Stage 1, capture:** on `sample_valid && en`, register `tdc_q` into `s1_q` and set `s1_v`.
- **Stage 2, bubble correction and edge search:**
  - Bubble correction: each bit is replaced by the majority of itself and its two neighbours. Bits 0 and NSTAGES-1 use the copied edge bit as the missing neighbour.
  - Edge search: priority encoders scan upward from bit 1 and find the first rise and the first fall.
  - A missing rise is encoded as `NSTAGES`, with a found-flag of 0. A missing fall is handled the same way.
- **Stage 3, outputs:**
  - Register `rise_pos`, `fall_pos`, `phase_out` and `edge_err`, and pulse `out_valid`.
  - `edge_err` = !rise_found && !fall_found. In that case `phase_out` = 0.
  - If both edges are found, the half-period measurement is `meas = |fall_pos - rise_pos|`. The average updates as `period_avg += (meas<<AVG_SH - period_avg) >>> AVG_SH`.
  - The update uses signed arithmetic, PW+AVG_SH+1 bits internally, then saturates to [0, 2^(PW+AVG_SH)-1].
- **Period state machine** (updates only in stage 3, only when both edges are found):
  - INIT → first valid measurement loads `period_avg = meas<<AVG_SH` directly, then moves to TRACK.
  - TRACK → IIR update on each valid measurement.
  - Any `rst` returns to INIT.
- **Enable:** `en` = 0 freezes all pipeline registers, including `s*_v` flags. `sample_valid` during that time is dropped.

## Timing
- Latency is exactly 3 `clk` cycles from a `sample_valid` edge to `out_valid`. Throughput is one sample per cycle.
- Back-to-back strobes produce back-to-back `out_valid` pulses with no bubbles.
- Reset values:
  - all outputs 0;
  - `period_avg` 0;
  - all valid flags 0;
  - state INIT.
- Reset mid-pipeline discards in-flight samples. No `out_valid` follows for them.
- `tdc_q` must meet setup to `clk`. The latch delay (tens of ps) is absorbed by the sampler of the instantiating design; this block assumes synchronous input.
- The outputs hold their last value between `out_valid` pulses.

## Configuration
- `TDC_BUBBLE_CORR_EN`:
  - Defined: the majority-of-3 correction is applied in stage 2.
  - Undefined: the raw `s1_q` feeds the encoders directly.
  - Latency is 3 cycles in both cases. The correction logic is simply absent when the macro is undefined.

## Test plan
- **Clean code.** NSTAGES=64. Send `tdc_q` = ones in bits 10..41, zeros elsewhere, then strobe. Expected 3 cycles later: `rise_pos`=10, `fall_pos`=42, `phase_out`=10, `edge_err`=0. The first `period_avg` = 32<<4 = 512.
- **Bubble.** Send the same word but with bit 20 cleared.
  - With `TDC_BUBBLE_CORR_EN`: outputs match the clean-code case.
  - Without it: `fall_pos`=20.
- **All-zero word.** Expected: `edge_err`=1, `phase_out`=0, `period_avg` unchanged. Repeat with an all-ones word; expected result is the same.
- **IIR tracking.** After INIT with meas=32, apply 16 samples with meas=48. `period_avg` rises monotonically toward 768, and the first update gives 512+16=528.
- **Back-to-back with a gap.** Send strobes on cycles 0, 1 and 2, then deassert `en` during cycle 3. Expected: `out_valid` on cycles 3, 4 and 5 shifted by the stall, with no sample lost or duplicated.
- **Reset mid-flight.** Strobe at cycle 0 and assert `rst` at cycle 1. Expected: no `out_valid`, and all outputs 0. After release, the next sample reloads `period_avg` via INIT.
